// File: rtl/radio_deser.sv
// Receive-side deserializer for the radio serial link: acquires frame alignment
// from the SYNC strobe and emits {R0_I, R0_Q, R1_I, R1_Q} words while locked.
module radio_deser #(
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2
) (
  input  logic        fast_clk,
  input  logic        rst_n,
  input  logic        data_in,
  input  logic        sync_in,
  output logic [1:0]  r0_i,
  output logic [1:0]  r0_q,
  output logic [1:0]  r1_i,
  output logic [1:0]  r1_q,
  output logic        word_valid,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SAMP_W = 2;
  localparam int unsigned TALLY_W = 4;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned SHIFT_W = 7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TALLY_W-1:0]   good_q, good_d;
  logic [TALLY_W-1:0]   bad_q, bad_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [SAMP_W-1:0]    r0_i_q, r0_i_d;
  logic [SAMP_W-1:0]    r0_q_q, r0_q_d;
  logic [SAMP_W-1:0]    r1_i_q, r1_i_d;
  logic [SAMP_W-1:0]    r1_q_q, r1_q_d;
  logic                 word_valid_q, word_valid_d;
  logic                 locked_q, locked_d;
  logic                 sync_err_q, sync_err_d;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  logic                 at_bit0_c;
  logic                 at_last_c;
  logic                 good_sync_c;
  logic                 miss_c;
  logic                 misplaced_c;
  logic [TALLY_W-1:0]   good_inc_c;
  logic [TALLY_W-1:0]   bad_inc_c;
  logic [FRAME_BITS-1:0] frame_c;

  assign at_bit0_c   = (bit_cnt_q == '0);
  assign at_last_c   = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign good_sync_c = sync_in & at_bit0_c;
  assign miss_c      = ~sync_in & at_bit0_c;
  assign misplaced_c = sync_in & ~at_bit0_c;
  assign good_inc_c  = good_q + TALLY_W'(1);
  assign bad_inc_c   = bad_q + TALLY_W'(1);
  // LSB arrives first, so the current sample is the MSB of the assembled frame
  assign frame_c     = {data_in, shift_q};

  // Next-state, alignment and word assembly
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
    good_d       = good_q;
    bad_d        = bad_q;
    shift_d      = {data_in, shift_q[SHIFT_W-1:1]};
    r0_i_d       = r0_i_q;
    r0_q_d       = r0_q_q;
    r1_i_d       = r1_i_q;
    r1_q_d       = r1_q_q;
    word_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      HUNT: begin
        if (sync_in) begin
          bit_cnt_d = CNT_W'(1);
          good_d    = '0;
          state_d   = VERIFY;
        end
      end
      VERIFY: begin
        if (good_sync_c) begin
          good_d = good_inc_c;
          if (good_inc_c == TALLY_W'(LOCK_COUNT)) begin
            state_d = LOCKED;
            bad_d   = '0;
          end
        end else if (miss_c) begin
          sync_err_d = 1'b1;
          state_d    = HUNT;
        end else if (misplaced_c) begin
          sync_err_d = 1'b1;
          bit_cnt_d  = CNT_W'(1);
          good_d     = '0;
        end
      end
      LOCKED: begin
        // Flywheel: bad syncs never move the alignment while locked
        if (good_sync_c) begin
          bad_d = '0;
        end else if (miss_c || misplaced_c) begin
          sync_err_d = 1'b1;
          bad_d      = bad_inc_c;
          if (bad_inc_c == TALLY_W'(LOSS_COUNT)) begin
            state_d = HUNT;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    if ((state_q == LOCKED) && at_last_c) begin
      r0_i_d       = frame_c[7:6];
      r0_q_d       = frame_c[5:4];
      r1_i_d       = frame_c[3:2];
      r1_q_d       = frame_c[1:0];
      word_valid_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      shift_q      <= '0;
      r0_i_q       <= '0;
      r0_q_q       <= '0;
      r1_i_q       <= '0;
      r1_q_q       <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      shift_q      <= shift_d;
      r0_i_q       <= r0_i_d;
      r0_q_q       <= r0_q_d;
      r1_i_q       <= r1_i_d;
      r1_q_q       <= r1_q_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign r0_i       = r0_i_q;
  assign r0_q       = r0_q_q;
  assign r1_i       = r1_i_q;
  assign r1_q       = r1_q_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_radio_deser.sv
// Frame-level directed bench for radio_deser: per-frame table of serial data,
// sync placement and expected word/error/lock/count results.
module tb_radio_deser;

  logic        fast_clk = 1'b0;
  logic        rst_n;
  logic        data_in;
  logic        sync_in;
  logic [1:0]  r0_i, r0_q, r1_i, r1_q;
  logic        word_valid;
  logic        locked;
  logic        sync_err;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  radio_deser #(.FRAME_BITS(8), .LOCK_COUNT(4), .LOSS_COUNT(2)) dut (
    .fast_clk   (fast_clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .sync_in    (sync_in),
    .r0_i       (r0_i),
    .r0_q       (r0_q),
    .r1_i       (r1_i),
    .r1_q       (r1_q),
    .word_valid (word_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] smask;
    int         nbits;
    bit         rst_before;
    bit         wrap;
    int         exp_w;
    int         exp_e;
    bit         exp_l;
    int         exp_c;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic [7:0] d, input logic [7:0] m, input int n,
                              input bit r, input bit w, input int ew, input int ee,
                              input bit el, input int ec);
    vec_t v;
    v.data = d; v.smask = m; v.nbits = n; v.rst_before = r; v.wrap = w;
    v.exp_w = ew; v.exp_e = ee; v.exp_l = el; v.exp_c = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] out_byte();
    return {r0_i, r0_q, r1_i, r1_q};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(out_byte()), 32'h0);
    check({tag, "_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_locked"}, 32'(locked), 32'h0);
    check({tag, "_err"},   32'(sync_err), 32'h0);
    check({tag, "_cnt"},   32'(frame_cnt), 32'h0);
  endtask

  task automatic run_frame(input vec_t v, output int nw, output int ne, output logic [7:0] wd);
    nw = 0; ne = 0; wd = 8'h00;
    for (int b = 0; b < v.nbits; b++) begin
      @(negedge fast_clk);
      data_in = v.data[b];
      sync_in = v.smask[b];
      if (v.wrap && b == 0) force dut.frame_cnt_d = 16'hFFFF;
      @(posedge fast_clk);
      #1;
      if (v.wrap && b == 0) release dut.frame_cnt_d;
      if (word_valid) begin
        nw++;
        wd = out_byte();
      end
      if (sync_err) ne++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, ne;
    logic [7:0] wd;
    logic [7:0] last_word;

    // acquisition from reset
    tbl[0]  = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(8'hB4, 8'h01, 8, 0, 0, 1, 0, 1, 1);
    tbl[5]  = mk(8'h3C, 8'h01, 8, 0, 0, 1, 0, 1, 2);
    // single missing sync, recovery, then two consecutive misses
    tbl[6]  = mk(8'hA5, 8'h00, 8, 0, 0, 1, 1, 1, 3);
    tbl[7]  = mk(8'h5A, 8'h01, 8, 0, 0, 1, 0, 1, 4);
    tbl[8]  = mk(8'h0F, 8'h00, 8, 0, 0, 1, 1, 1, 5);
    tbl[9]  = mk(8'hF0, 8'h00, 8, 0, 0, 0, 1, 0, 5);
    tbl[10] = mk(8'h11, 8'h00, 8, 0, 0, 0, 0, 0, 5);
    // HUNT sync, then a sync landing at bit_cnt=3 in VERIFY
    tbl[11] = mk(8'h00, 8'h01, 3, 0, 0, 0, 0, 0, 5);
    tbl[12] = mk(8'hC3, 8'h01, 8, 0, 0, 0, 1, 0, 5);
    tbl[13] = mk(8'h96, 8'h01, 8, 0, 0, 0, 0, 0, 5);
    tbl[14] = mk(8'h69, 8'h01, 8, 0, 0, 0, 0, 0, 5);
    tbl[15] = mk(8'h81, 8'h01, 8, 0, 0, 0, 0, 0, 5);
    tbl[16] = mk(8'h7E, 8'h01, 8, 0, 0, 1, 0, 1, 6);
    tbl[17] = mk(8'hE7, 8'h01, 8, 0, 0, 1, 0, 1, 7);
    // partial locked frame, reset at bit 4, reacquire
    tbl[18] = mk(8'h24, 8'h01, 4, 0, 0, 0, 0, 1, 7);
    tbl[19] = mk(8'hB4, 8'h01, 8, 1, 0, 0, 0, 0, 0);
    tbl[20] = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(8'hB4, 8'h01, 8, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(8'hB4, 8'h01, 8, 0, 0, 1, 0, 1, 1);
    // frame_cnt preset to 0xFFFF wraps on the next word
    tbl[24] = mk(8'hD2, 8'h01, 8, 0, 1, 1, 0, 1, 0);
    tbl[25] = mk(8'h4B, 8'h01, 8, 0, 0, 1, 0, 1, 1);

    rst_n = 1'b0;
    data_in = 1'b0;
    sync_in = 1'b0;
    last_word = 8'h00;
    repeat (2) @(posedge fast_clk);
    #1;
    check_all_zero("por");
    @(negedge fast_clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].rst_before) begin
        @(negedge fast_clk);
        data_in = 1'b1;
        sync_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero($sformatf("f%0d_rst", i));
        repeat (2) @(negedge fast_clk);
        check_all_zero($sformatf("f%0d_rsthold", i));
        rst_n = 1'b1;
        last_word = 8'h00;
      end
      run_frame(tbl[i], nw, ne, wd);
      check($sformatf("f%0d_words", i), 32'(nw), 32'(tbl[i].exp_w));
      check($sformatf("f%0d_errs", i), 32'(ne), 32'(tbl[i].exp_e));
      check($sformatf("f%0d_locked", i), 32'(locked), 32'(tbl[i].exp_l));
      check($sformatf("f%0d_cnt", i), 32'(frame_cnt), 32'(tbl[i].exp_c));
      if (tbl[i].exp_w > 0) begin
        check($sformatf("f%0d_word", i), 32'(wd), 32'(tbl[i].data));
        last_word = tbl[i].data;
      end
      check($sformatf("f%0d_hold", i), 32'(out_byte()), 32'(last_word));
    end

    // one more bit: the pulse from the last word must be gone
    @(negedge fast_clk);
    data_in = 1'b0;
    sync_in = 1'b1;
    @(posedge fast_clk);
    #1;
    check("pulse_width", 32'(word_valid), 32'h0);
    check("final_locked", 32'(locked), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/radio_deser.md
Name: radio_deser

Overview:
- Receive-side deserializer for the radio module serial link; sits on the correlator/aggregation FPGA.
- Recovers the 8-bit radio sample frames {R0_I, R0_Q, R1_I, R1_Q} from the single-bit DATA_OUT stream, sent LSB first.
- Uses a frame-start strobe from the SYNC line to acquire frame alignment, verify it and hold it.
- Outputs parallel I/Q pairs per radio with a one-cycle valid pulse, plus lock and error status.

Parameters:
- FRAME_BITS, 8: bits per serial frame; must be 8.
- LOCK_COUNT, 4: consecutive correctly placed syncs needed to go from VERIFY to LOCKED; range 1..15.
- LOSS_COUNT, 2: consecutive bad sync events in LOCKED that force HUNT; range 1..15.

Ports:
- fast_clk  in  1  serial bit clock; one data bit is sampled per rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  1  serial data, already synchronous to fast_clk.
- sync_in  in  1  high on the fast_clk cycle that carries frame bit 0.
- r0_i  out  2  radio 0 I, taken from frame bits [7:6].
- r0_q  out  2  radio 0 Q, taken from frame bits [5:4].
- r1_i  out  2  radio 1 I, taken from frame bits [3:2].
- r1_q  out  2  radio 1 Q, taken from frame bits [1:0].
- word_valid  out  1  one-cycle pulse when a new word is presented.
- locked  out  1  high while the state is LOCKED.
- sync_err  out  1  one-cycle pulse on each bad sync event in VERIFY or LOCKED.
- frame_cnt  out  16  count of emitted words; wraps from 0xFFFF to 0.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state HUNT; bit counter 0; good and bad counters 0; shift register 0.
  - Takes effect mid-frame with no partial word emitted.
- Bit counter bit_cnt (0..7):
  - The sample at bit_cnt==k is frame bit k; the first bit received is bit 0 = r1_q[0].
  - bit_cnt increments each edge and wraps 7 to 0.
  - On an accepted alignment sync, the sampled bit is bit 0 and the next bit_cnt is 1.
- Sync classification (VERIFY and LOCKED only), evaluated on each edge against the current bit_cnt:
  - Good: sync_in=1 and bit_cnt==0.
  - Miss: sync_in=0 and bit_cnt==0.
  - Misplaced: sync_in=1 and bit_cnt!=0.
  - Miss and misplaced are both bad events. A single frame can produce more than one bad event.
- HUNT:
  - data_in is ignored.
  - On sync_in=1: align to this edge, good=0, go to VERIFY.
- VERIFY:
  - Good: good+1. If good+1 == LOCK_COUNT, go to LOCKED and clear bad.
  - Miss: pulse sync_err, go to HUNT.
  - Misplaced: pulse sync_err, realign to this edge (sampled bit is bit 0), good=0, stay in VERIFY.
- LOCKED:
  - Good: bad=0.
  - Bad event: pulse sync_err, bad+1, keep the current alignment (flywheel).
  - If bad+1 == LOSS_COUNT: go to HUNT, drop locked. A sync_in on that same edge is not used for alignment; HUNT waits for the next sync.
- Word output:
  - Triggered on the edge that samples bit 7 while the state is LOCKED, including the edge on which the state enters LOCKED.
  - On that edge, register the full byte into r0_i/r0_q/r1_i/r1_q, set word_valid=1 for the following cycle only, and increment frame_cnt.
  - Latency: word_valid rises 1 cycle after bit 7 is sampled.
  - Data outputs hold their value between words and after lock loss.
- Timing values:
  - The first word after acquisition is the frame whose bit 0 arrives with the LOCK_COUNT-th good sync.
  - Throughput: at most one word every 8 cycles.
- locked is a registered copy of the state (state==LOCKED) and changes on the same edge as the state transition.

Test Plan:
- Continuous frames of 0xB4 (serial 0,0,1,0,1,1,0,1) with a sync on every bit 0:
  - HUNT at sync #1, LOCKED after sync #5.
  - First word_valid 8 cycles after sync #5 (1 cycle after that frame's bit 7), carrying r0_i=2, r0_q=3, r1_i=1, r1_q=0.
  - One pulse every 8 cycles after that; frame_cnt increments 1, 2, 3…
- Locked stream with one sync removed: one sync_err pulse, locked stays 1, words keep flowing with correct data, and the next good sync clears the bad counter.
- Locked stream with two consecutive syncs removed: two sync_err pulses, locked falls on the second missing-sync edge, and word_valid stops.
- In VERIFY, a misplaced sync at bit_cnt=3:
  - sync_err pulses and alignment moves to that edge.
  - Lock needs 4 further good syncs.
  - Decoded words match frames aligned to the new position.
- rst_n asserted at bit 4 of a locked frame: all outputs 0 immediately and no word for that frame. After release, reacquire with the same timing as the first scenario.
- frame_cnt preloaded (force) to 0xFFFF: the next word sets frame_cnt to 0x0000 and word_valid pulses normally.
